gb_cpu_interrupt_ctrl: RTL and testbench

Interrupt controller and dispatch sequencer for the Game Boy CPU. It holds the IE (FFFF) and IF (FF0F) registers and the IME flag, and resolves pending-interrupt priority. It manages HALT entry and exit. On dispatch it drives a fixed 5-M-cycle sequence of strobes to the control unit and register file: SP decrement, PC pushes, and the `write_interrupt_vector`/`interrupt_vector` load of PC.

---
 rtl/gb_cpu_interrupt_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl
// Game Boy CPU interrupt controller: IE/IF/IME state, lowest-bit-first
// priority, HALT entry/exit and the 5-M-cycle dispatch strobe sequence.
// Optional build macro: GB_HALT_BUG_EN enables the HALT-bug pulse on
// halt_bug; without it halt_bug is tied low.
// dbg_state exposes the dispatch FSM state for observation.
module gb_cpu_interrupt_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] irq_req,
    input  logic       ie_wren,
    input  logic       if_wren,
    input  logic [7:0] bus_wdata,
    input  logic       instr_boundary,
    input  logic       ei_cmd,
    input  logic       di_cmd,
    input  logic       reti_cmd,
    input  logic       halt_cmd,
    output logic [7:0] ie_reg,
    output logic [7:0] if_reg,
    output logic       ime,
    output logic       halted,
    output logic       cpu_stall,
    output logic       dispatch_active,
    output logic       dispatch_sp_dec,
    output logic       dispatch_push_hi,
    output logic       dispatch_push_lo,
    output logic       write_interrupt_vector,
    output logic [7:0] interrupt_vector,
    output logic       halt_bug,
    output logic [2:0] dbg_state
);

    // Strobe protocol: every dispatch_* strobe and write_interrupt_vector is
    // a single-cycle pulse with no back-pressure; the control unit must act
    // on it in the cycle it is high. dispatch_active frames the whole burst.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        D_WAIT    = 3'd1,
        D_SPDEC   = 3'd2,
        D_PUSH_HI = 3'd3,
        D_PUSH_LO = 3'd4,
        D_VECTOR  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_ie;
    logic [4:0] r_if;
    logic       r_ime;
    logic       r_ei_delay;
    logic       r_halted;
    logic       r_active;
    logic       r_sp_dec;
    logic       r_push_hi;
    logic       r_push_lo;
    logic       r_wiv;
    logic [7:0] r_vector;
    logic [4:0] r_ack_mask;

    logic [4:0] w_pend;
    logic       w_pend_any;
    logic       w_bnd;
    logic       w_ime_eff;
    logic       w_start;
    logic [4:0] w_if_next;
    logic [7:0] w_pri_vec;
    logic [4:0] w_pri_mask;

    // Pending set and boundary qualification; boundaries are ignored while
    // dispatching or halted since the CPU is not executing then.
    always_comb begin
        w_pend     = r_ie[4:0] & r_if;
        w_pend_any = |w_pend;
        w_bnd      = instr_boundary & (r_state == IDLE) & ~r_halted;
        w_ime_eff  = (r_ime | r_ei_delay | reti_cmd) & ~di_cmd;
        w_start    = (w_bnd & w_ime_eff & w_pend_any)
                   | (r_halted & w_pend_any & r_ime);
    end

    // Lowest pending bit wins; no pending bit yields vector 0x00 and no ack.
    always_comb begin
        w_pri_vec  = 8'h00;
        w_pri_mask = 5'b00000;
        if (w_pend[0]) begin
            w_pri_vec  = 8'h40;
            w_pri_mask = 5'b00001;
        end else if (w_pend[1]) begin
            w_pri_vec  = 8'h48;
            w_pri_mask = 5'b00010;
        end else if (w_pend[2]) begin
            w_pri_vec  = 8'h50;
            w_pri_mask = 5'b00100;
        end else if (w_pend[3]) begin
            w_pri_vec  = 8'h58;
            w_pri_mask = 5'b01000;
        end else if (w_pend[4]) begin
            w_pri_vec  = 8'h60;
            w_pri_mask = 5'b10000;
        end
    end

    // IF next value: bus write, then acknowledge clear, then new requests on top.
    always_comb begin
        w_if_next = r_if;
        if (if_wren) begin
            w_if_next = bus_wdata[4:0];
        end
        if (r_state == D_VECTOR) begin
            w_if_next = w_if_next & ~r_ack_mask;
        end
        w_if_next = w_if_next | irq_req;
    end

    // Dispatch sequencer next state: fixed one-cycle-per-state walk.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_start) w_next_state = D_WAIT;
            D_WAIT:    w_next_state = D_SPDEC;
            D_SPDEC:   w_next_state = D_PUSH_HI;
            D_PUSH_HI: w_next_state = D_PUSH_LO;
            D_PUSH_LO: w_next_state = D_VECTOR;
            D_VECTOR:  w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // State register plus registered strobes decoded from the next state;
    // the vector is resolved late, after the high-byte push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_active   <= 1'b0;
            r_sp_dec   <= 1'b0;
            r_push_hi  <= 1'b0;
            r_push_lo  <= 1'b0;
            r_wiv      <= 1'b0;
            r_vector   <= 8'h00;
            r_ack_mask <= 5'b00000;
        end else begin
            r_state   <= w_next_state;
            r_active  <= (w_next_state != IDLE);
            r_sp_dec  <= (w_next_state == D_SPDEC);
            r_push_hi <= (w_next_state == D_PUSH_HI);
            r_push_lo <= (w_next_state == D_PUSH_LO);
            r_wiv     <= (w_next_state == D_VECTOR);
            if (r_state == D_PUSH_LO) begin
                r_vector   <= w_pri_vec;
                r_ack_mask <= w_pri_mask;
            end
        end
    end

    // IE and IF registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie <= 8'h00;
            r_if <= 5'b00000;
        end else begin
            if (ie_wren) begin
                r_ie <= bus_wdata;
            end
            r_if <= w_if_next;
        end
    end

    // IME with the one-instruction EI delay; dispatch entry overrides all.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ime      <= 1'b0;
            r_ei_delay <= 1'b0;
        end else if (w_start) begin
            r_ime      <= 1'b0;
            r_ei_delay <= 1'b0;
        end else if (w_bnd) begin
            if (di_cmd) begin
                r_ime      <= 1'b0;
                r_ei_delay <= 1'b0;
            end else begin
                if (r_ei_delay | reti_cmd) begin
                    r_ime <= 1'b1;
                end
                r_ei_delay <= ei_cmd;
            end
        end
    end

    // HALT entry with nothing pending; any pending interrupt wakes, IME or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (r_halted) begin
            if (w_pend_any) begin
                r_halted <= 1'b0;
            end
        end else if (w_bnd & halt_cmd & ~w_pend_any) begin
            r_halted <= 1'b1;
        end
    end

`ifdef GB_HALT_BUG_EN
    logic r_halt_bug;

    // HALT with pending interrupt but IME off: one-cycle PC-increment skip.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halt_bug <= 1'b0;
        end else begin
            r_halt_bug <= w_bnd & halt_cmd & w_pend_any & ~w_ime_eff;
        end
    end

    assign halt_bug = r_halt_bug;
`else
    assign halt_bug = 1'b0;
`endif

    assign ie_reg                 = r_ie;
    assign if_reg                 = {3'b111, r_if};
    assign ime                    = r_ime;
    assign halted                 = r_halted;
    assign cpu_stall              = r_halted | r_active;
    assign dispatch_active        = r_active;
    assign dispatch_sp_dec        = r_sp_dec;
    assign dispatch_push_hi       = r_push_hi;
    assign dispatch_push_lo       = r_push_lo;
    assign write_interrupt_vector = r_wiv;
    assign interrupt_vector       = r_vector;
    assign dbg_state              = r_state;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Testbench for gb_cpu_interrupt_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_gb_cpu_interrupt_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] irq_req;
    logic       ie_wren;
    logic       if_wren;
    logic [7:0] bus_wdata;
    logic       instr_boundary;
    logic       ei_cmd;
    logic       di_cmd;
    logic       reti_cmd;
    logic       halt_cmd;
    logic [7:0] ie_reg;
    logic [7:0] if_reg;
    logic       ime;
    logic       halted;
    logic       cpu_stall;
    logic       dispatch_active;
    logic       dispatch_sp_dec;
    logic       dispatch_push_hi;
    logic       dispatch_push_lo;
    logic       write_interrupt_vector;
    logic [7:0] interrupt_vector;
    logic       halt_bug;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    gb_cpu_interrupt_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .irq_req                (irq_req),
        .ie_wren                (ie_wren),
        .if_wren                (if_wren),
        .bus_wdata              (bus_wdata),
        .instr_boundary         (instr_boundary),
        .ei_cmd                 (ei_cmd),
        .di_cmd                 (di_cmd),
        .reti_cmd               (reti_cmd),
        .halt_cmd               (halt_cmd),
        .ie_reg                 (ie_reg),
        .if_reg                 (if_reg),
        .ime                    (ime),
        .halted                 (halted),
        .cpu_stall              (cpu_stall),
        .dispatch_active        (dispatch_active),
        .dispatch_sp_dec        (dispatch_sp_dec),
        .dispatch_push_hi       (dispatch_push_hi),
        .dispatch_push_lo       (dispatch_push_lo),
        .write_interrupt_vector (write_interrupt_vector),
        .interrupt_vector       (interrupt_vector),
        .halt_bug               (halt_bug),
        .dbg_state              (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // m_phase counts M-cycles into a dispatch: 0 none, 1..5 = wait, SP dec,
    // push hi, push lo, vector load.
    logic [7:0] m_ie;
    logic [4:0] m_if;
    logic       m_ime;
    logic       m_eid;
    logic       m_halted;
    int         m_phase;
    logic [7:0] m_vec;
    logic [4:0] m_ack;
    logic       m_hbug;

    function automatic int lowest_bit(input logic [4:0] p);
        for (int i = 0; i < 5; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [4:0] pend;
        logic [4:0] nif;
        logic       bnd;
        logic       eff;
        logic       start;
        int         idx;
        if (reset) begin
            m_ie = 8'h00; m_if = 5'h00; m_ime = 1'b0; m_eid = 1'b0;
            m_halted = 1'b0; m_phase = 0; m_vec = 8'h00; m_ack = 5'h00;
            m_hbug = 1'b0;
            return;
        end
        pend  = m_ie[4:0] & m_if;
        bnd   = instr_boundary && (m_phase == 0) && !m_halted;
        eff   = (m_ime || m_eid || reti_cmd) && !di_cmd;
        start = (bnd && eff && (pend != 0)) || (m_halted && (pend != 0) && m_ime);

        nif = if_wren ? bus_wdata[4:0] : m_if;
        if (m_phase == 5) nif = nif & ~m_ack;
        nif = nif | irq_req;

        if (m_phase == 4) begin
            idx = lowest_bit(pend);
            if (idx < 0) begin
                m_vec = 8'h00;
                m_ack = 5'h00;
            end else begin
                m_vec = 8'(64 + 8 * idx);
                m_ack = 5'(1 << idx);
            end
        end

`ifdef GB_HALT_BUG_EN
        m_hbug = bnd && halt_cmd && (pend != 0) && !eff;
`else
        m_hbug = 1'b0;
`endif

        if (m_halted) begin
            if (pend != 0) m_halted = 1'b0;
        end else if (bnd && halt_cmd && (pend == 0)) begin
            m_halted = 1'b1;
        end

        if (start) begin
            m_ime = 1'b0;
            m_eid = 1'b0;
        end else if (bnd) begin
            if (di_cmd) begin
                m_ime = 1'b0;
                m_eid = 1'b0;
            end else begin
                if (m_eid || reti_cmd) m_ime = 1'b1;
                m_eid = ei_cmd;
            end
        end

        if (m_phase != 0) m_phase = (m_phase == 5) ? 0 : m_phase + 1;
        else if (start)   m_phase = 1;

        m_if = nif;
        if (ie_wren) m_ie = bus_wdata;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ie_reg",           ie_reg,                 m_ie);
        chk("if_reg",           if_reg,                 {3'b111, m_if});
        chk("ime",              {7'b0, ime},            {7'b0, m_ime});
        chk("halted",           {7'b0, halted},         {7'b0, m_halted});
        chk("cpu_stall",        {7'b0, cpu_stall},      {7'b0, m_halted || (m_phase != 0)});
        chk("dispatch_active",  {7'b0, dispatch_active},{7'b0, m_phase != 0});
        chk("sp_dec",           {7'b0, dispatch_sp_dec},{7'b0, m_phase == 2});
        chk("push_hi",          {7'b0, dispatch_push_hi},{7'b0, m_phase == 3});
        chk("push_lo",          {7'b0, dispatch_push_lo},{7'b0, m_phase == 4});
        chk("write_vector",     {7'b0, write_interrupt_vector},{7'b0, m_phase == 5});
        chk("interrupt_vector", interrupt_vector,       m_vec);
        chk("halt_bug",         {7'b0, halt_bug},       {7'b0, m_hbug});
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        reset = 1'b0; irq_req = 5'h00; ie_wren = 1'b0; if_wren = 1'b0;
        bus_wdata = 8'h00; instr_boundary = 1'b0; ei_cmd = 1'b0;
        di_cmd = 1'b0; reti_cmd = 1'b0; halt_cmd = 1'b0;
    endtask

    // One M-cycle: inputs set by the caller are sampled at the edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc();
        reset = 1'b1; cyc();
    endtask

    task automatic wr_ie(input logic [7:0] v);
        ie_wren = 1'b1; bus_wdata = v; cyc();
    endtask

    task automatic irq(input logic [4:0] v);
        irq_req = v; cyc();
    endtask

    task automatic bnd(input logic ei, input logic di, input logic reti, input logic hlt);
        instr_boundary = 1'b1; ei_cmd = ei; di_cmd = di; reti_cmd = reti; halt_cmd = hlt;
        cyc();
    endtask

    // Called with the sequencer in its first (wait) cycle.
    task automatic run_dispatch(input string tag, input logic [7:0] exp_vec);
        repeat (4) cyc();
        chk(tag, interrupt_vector, exp_vec);
        chk({tag, "_wiv"}, {7'b0, write_interrupt_vector}, 8'h01);
        cyc();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        m_ie = 8'h00; m_if = 5'h00; m_ime = 1'b0; m_eid = 1'b0; m_halted = 1'b0;
        m_phase = 0; m_vec = 8'h00; m_ack = 5'h00; m_hbug = 1'b0;

        // Reset values
        do_reset();
        chk("rst_if", if_reg, 8'hE0);
        chk("rst_ie", ie_reg, 8'h00);

        // Timer interrupt enabled and raised
        wr_ie(8'h05);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        chk("reti_ime", {7'b0, ime}, 8'h01);
        irq(5'h04);
        chk("irq_visible", if_reg, 8'hE4);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_active", {7'b0, dispatch_active}, 8'h01);
        run_dispatch("vec_timer", 8'h50);
        chk("timer_if_clear", if_reg, 8'hE0);
        chk("timer_ime_off", {7'b0, ime}, 8'h00);

        // Priority ordering
        do_reset();
        wr_ie(8'h1F);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        irq(5'h18);
        irq(5'h02);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        run_dispatch("vec_stat", 8'h48);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        run_dispatch("vec_serial", 8'h58);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        run_dispatch("vec_joypad", 8'h60);
        chk("prio_if_empty", if_reg, 8'hE0);

        // EI delay: honoured one boundary later
        do_reset();
        wr_ie(8'h04);
        irq(5'h04);
        bnd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ei_no_dispatch", {7'b0, dispatch_active}, 8'h00);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ei_dispatch", {7'b0, dispatch_active}, 8'h01);
        run_dispatch("vec_ei", 8'h50);

        // EI then DI: never dispatches
        do_reset();
        wr_ie(8'h04);
        irq(5'h04);
        bnd(1'b1, 1'b0, 1'b0, 1'b0);
        bnd(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        chk("eidi_no_dispatch", {7'b0, dispatch_active}, 8'h00);
        chk("eidi_ime", {7'b0, ime}, 8'h00);

        // Vector cancel: IE cleared during the high-byte push
        do_reset();
        wr_ie(8'h01);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        irq(5'h01);
        bnd(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("cancel_push_hi", {7'b0, dispatch_push_hi}, 8'h01);
        ie_wren = 1'b1; bus_wdata = 8'h00;
        cyc();
        cyc();
        chk("cancel_vec", interrupt_vector, 8'h00);
        cyc();
        chk("cancel_if", if_reg, 8'hE1);

        // HALT with IME off: wake without dispatch
        do_reset();
        wr_ie(8'h01);
        bnd(1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt_enter", {7'b0, halted}, 8'h01);
        irq(5'h01);
        cyc();
        chk("halt_exit", {7'b0, halted}, 8'h00);
        chk("halt_no_disp", {7'b0, dispatch_active}, 8'h00);
        cyc();

        // HALT with IME on: wake and dispatch together
        do_reset();
        wr_ie(8'h01);
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        bnd(1'b0, 1'b0, 1'b0, 1'b1);
        irq(5'h01);
        cyc();
        chk("wake_disp", {7'b0, dispatch_active}, 8'h01);
        run_dispatch("vec_wake", 8'h40);

        // HALT with pending interrupt and IME off
        do_reset();
        wr_ie(8'h01);
        irq(5'h01);
        bnd(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef GB_HALT_BUG_EN
        chk("halt_bug_pulse", {7'b0, halt_bug}, 8'h01);
`else
        chk("halt_bug_tied", {7'b0, halt_bug}, 8'h00);
`endif
        chk("halt_bug_nohalt", {7'b0, halted}, 8'h00);
        cyc();
        chk("halt_bug_end", {7'b0, halt_bug}, 8'h00);

        // Reset during the low-byte push
        bnd(1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("mid_push_lo", {7'b0, dispatch_push_lo}, 8'h01);
        reset = 1'b1;
        cyc();
        chk("mid_rst_active", {7'b0, dispatch_active}, 8'h00);
        chk("mid_rst_vec", interrupt_vector, 8'h00);
        chk("mid_rst_if", if_reg, 8'hE0);
        chk("mid_rst_ie", ie_reg, 8'h00);
        chk("mid_rst_wiv", {7'b0, write_interrupt_vector}, 8'h00);
        cyc();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) irq_req = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 9) == 0) begin
                ie_wren = 1'b1;
                bus_wdata = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 14) == 0) begin
                if_wren = 1'b1;
                bus_wdata = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 2) == 0) begin
                instr_boundary = 1'b1;
                case ($urandom_range(0, 7))
                    0: ei_cmd   = 1'b1;
                    1: di_cmd   = 1'b1;
                    2, 3: reti_cmd = 1'b1;
                    4: halt_cmd = 1'b1;
                    default: ;
                endcase
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
